// File: rtl/cpu_pkg.sv
// Shared RV32 core definitions: datapath width, reset/bubble defaults,
// control-transfer opcodes and the IF/ID pipeline register layout.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // addi x0,x0,0: harmless encoding that decode treats as "do nothing".
  localparam logic [31:0]     DEFAULT_NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Source of the next fetch address.
  typedef enum logic [1:0] {
    PC_SEL_SEQ,
    PC_SEL_HOLD,
    PC_SEL_REDIRECT
  } pc_sel_e;

  // Contents of the IF/ID slot handed to decode.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } if_id_t;

  // Instructions are word aligned; the low two target bits carry no meaning.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // True for opcodes that can redirect the fetch stream.
  function automatic logic is_ctrl_transfer(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Fetch PC generator: holds the address the instruction memory sampled on
// the last edge (pc_q), whether the word returning now is wanted (f_valid),
// and the priority mux that picks the next fetch address.
module if_pc_gen
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            f_valid_o
);

  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            f_valid_d, f_valid_q;

  // Select the next-PC source: redirect beats stall; an idle fetch re-reads.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_sel = PC_SEL_SEQ;
    if (redirect_i)                 pc_sel = PC_SEL_REDIRECT;
    else if (stall_i || !f_valid_q) pc_sel = PC_SEL_HOLD;
  end

  // Form the next fetch address; sequential fetch wraps modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel)
      PC_SEL_REDIRECT: pc_d = align_word(redirect_pc_i);
      PC_SEL_HOLD:     pc_d = pc_q;
      PC_SEL_SEQ:      pc_d = pc_q + XLEN'(4);
      default:         pc_d = pc_q;
    endcase
  end

  // Once out of reset every sampled address is wanted, including a redirect
  // target, which the memory samples on the same edge as the redirect.
  assign f_valid_d = 1'b1;

  // PC and fetch-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      f_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      pc_q      <= pc_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;
  assign f_valid_o = f_valid_q;

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register. Absorbs load-use stalls
// and EX redirects; squashed slots reach decode as NOP_INST with
// id_valid=0. Decode fields are plain slices of id_inst.
// Optional: define IF_PERF_CNT_EN to build the fetch/bubble counters;
// otherwise both counter ports are tied to zero.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0]     NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] im_addr,
  input  logic [31:0]     im_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_func3,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic            f_valid;
  logic            if_id_load;
  if_id_t          if_id_d, if_id_q;

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc_q),
    .pc_next_o     (pc_next),
    .f_valid_o     (f_valid)
  );

  assign im_addr = pc_next;

  // The slot is written on redirect (squash) or when not stalled.
  assign if_id_load = redirect || !stall;

  // IF/ID next state: squash on redirect, hold on stall, else capture fetch.
  always_comb begin
    if_id_d = if_id_q;
    if (redirect) begin
      if_id_d = '{valid: 1'b0, pc: pc_q, inst: NOP_INST};
    end else if (!stall) begin
      if_id_d.valid = f_valid;
      if_id_d.pc    = pc_q;
      if_id_d.inst  = f_valid ? im_rdata : NOP_INST;
    end
  end

  // IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= '{valid: 1'b0, pc: RESET_PC, inst: NOP_INST};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign id_valid  = if_id_q.valid;
  assign id_pc     = if_id_q.pc;
  assign id_inst   = if_id_q.inst;
  assign id_opcode = if_id_q.inst[6:0];
  assign id_func3  = if_id_q.inst[14:12];
  assign id_rs1    = if_id_q.inst[19:15];
  assign id_rs2    = if_id_q.inst[24:20];
  assign id_rd     = if_id_q.inst[11:7];

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_d, fetch_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  // Count what each load of the slot delivers; stalled edges count neither.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (if_id_load) begin
      if (if_id_d.valid) fetch_cnt_d  = fetch_cnt_q + 32'd1;
      else               bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Performance counter registers, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_load;
  assign unused_load     = if_id_load;
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage. A synchronous instruction memory
// returns a hashed word per address. The reference model tracks the fetch
// stream at program level: the next instruction owed to decode, whether a
// fetch is in flight, and the expected IF/ID slot and counters.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [6:0]  id_opcode;
  logic [2:0]  id_func3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_next;
  logic        m_warm;
  logic [31:0] m_fetch;
  logic [31:0] m_bubble;

  if_id_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .im_addr         (im_addr),
    .im_rdata        (im_rdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_opcode       (id_opcode),
    .id_func3        (id_func3),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Synchronous instruction memory.
  always @(posedge clk) im_rdata <= mem_word(im_addr);

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = 32'h0;
    m_inst   = NOP;
    m_next   = 32'h0;
    m_warm   = 1'b0;
    m_fetch  = 32'h0;
    m_bubble = 32'h0;
  endtask

  // Address the memory should be given this cycle.
  function automatic logic [31:0] exp_addr(input logic s, input logic r, input logic [31:0] t);
    if (r) return {t[31:2], 2'b00};
    if (s || !m_warm) return m_next;
    return m_next + 32'd4;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
    if (r) begin
      m_valid = 1'b0; m_pc = m_next; m_inst = NOP;
      m_next  = {t[31:2], 2'b00};
      m_bubble++;
    end else if (!s) begin
      if (!m_warm) begin
        m_valid = 1'b0; m_pc = m_next; m_inst = NOP;
        m_bubble++;
      end else begin
        m_valid = 1'b1; m_pc = m_next; m_inst = mem_word(m_next);
        m_next  = m_next + 32'd4;
        m_fetch++;
      end
    end
    m_warm = 1'b1;
  endtask

  // Drive one cycle (entered at posedge+1) and compare against the model.
  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] ef, eb;
    stall = s; redirect = r; redirect_pc = t;
    @(negedge clk);
    checks++;
    if (im_addr !== exp_addr(s, r, t)) begin
      errors++; $display("FAIL im_addr: got %h expected %h", im_addr, exp_addr(s, r, t));
    end
    @(posedge clk);
    model_edge(s, r, t);
    #1;
    checks++;
    if (id_valid !== m_valid) begin
      errors++; $display("FAIL id_valid: got %b expected %b", id_valid, m_valid);
    end
    checks++;
    if (id_pc !== m_pc) begin
      errors++; $display("FAIL id_pc: got %h expected %h", id_pc, m_pc);
    end
    checks++;
    if (id_inst !== m_inst) begin
      errors++; $display("FAIL id_inst: got %h expected %h", id_inst, m_inst);
    end
    checks++;
    if ({id_opcode, id_func3, id_rs1, id_rs2, id_rd} !==
        {m_inst[6:0], m_inst[14:12], m_inst[19:15], m_inst[24:20], m_inst[11:7]}) begin
      errors++; $display("FAIL id_fields: got %h expected inst %h", {id_opcode, id_func3, id_rs1, id_rs2, id_rd}, m_inst);
    end
`ifdef IF_PERF_CNT_EN
    ef = m_fetch; eb = m_bubble;
`else
    ef = 32'h0; eb = 32'h0;
`endif
    checks++;
    if (perf_fetch_cnt !== ef || perf_bubble_cnt !== eb) begin
      errors++; $display("FAIL perf_cnt: got %0d/%0d expected %0d/%0d", perf_fetch_cnt, perf_bubble_cnt, ef, eb);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== NOP || im_addr !== 32'h0) begin
      errors++;
      $display("FAIL %s: got valid=%b pc=%h inst=%h addr=%h expected 0/0/%h/0", tag, id_valid, id_pc, id_inst, im_addr, NOP);
    end
    checks++;
    if (perf_fetch_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin
      errors++; $display("FAIL %s_cnt: got %0d/%0d expected 0/0", tag, perf_fetch_cnt, perf_bubble_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycle(0, 0, 0);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL first_edge_bubble: got %b expected 0", id_valid);
    end
    cycle(0, 0, 0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== mem_word(32'h0)) begin
      errors++; $display("FAIL first_inst: got %b/%h/%h expected 1/0/%h", id_valid, id_pc, id_inst, mem_word(32'h0));
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 2; i++) begin
      cycle(0, 0, 0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_inst !== mem_word(32'(4 * i))) begin
        errors++; $display("FAIL stream_%0d: got %b/%h/%h expected 1/%h", i, id_valid, id_pc, id_inst, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #1;
      checks++;
      if (im_addr !== 32'd12) begin
        errors++; $display("FAIL stall_addr: got %h expected 0000000c", im_addr);
      end
      cycle(1, 0, 0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'd8) begin
        errors++; $display("FAIL stall_hold: got %b/%h expected 1/00000008", id_valid, id_pc);
      end
    end
    cycle(0, 0, 0);
    checks++;
    if (id_pc !== 32'd12 || id_inst !== mem_word(32'd12)) begin
      errors++; $display("FAIL stall_resume: got %h/%h expected 0000000c/%h", id_pc, id_inst, mem_word(32'd12));
    end
  endtask

  task automatic test_redirect();
    cycle(0, 1, 32'h0000_0100);
    checks++;
    if (id_valid !== 1'b0 || id_inst !== NOP || id_opcode !== 7'b0010011) begin
      errors++; $display("FAIL redirect_bubble: got %b/%h/%b expected 0/%h/0010011", id_valid, id_inst, id_opcode, NOP);
    end
    cycle(0, 0, 0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100) begin
      errors++; $display("FAIL redirect_target: got %b/%h expected 1/00000100", id_valid, id_pc);
    end
  endtask

  task automatic test_stall_redirect();
    cycle(1, 1, 32'h0000_0203);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL stall_redirect_bubble: got %b expected 0", id_valid);
    end
    cycle(0, 0, 0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      errors++; $display("FAIL stall_redirect_target: got %b/%h expected 1/00000200", id_valid, id_pc);
    end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0);
    checks++;
    if (id_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_last: got %h expected fffffffc", id_pc);
    end
    cycle(0, 0, 0);
    checks++;
    if (id_pc !== 32'h0 || id_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_zero: got %b/%h expected 1/00000000", id_valid, id_pc);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] ef, eb;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst_n = 1'b1;
    // 1 post-reset bubble, 6 valid, redirect bubble, 4 valid.
    for (int i = 0; i < 7; i++) cycle(0, 0, 0);
    cycle(0, 1, 32'h0000_0040);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
`ifdef IF_PERF_CNT_EN
    ef = 32'd10; eb = 32'd2;
`else
    ef = 32'd0; eb = 32'd0;
`endif
    checks++;
    if (perf_fetch_cnt !== ef || perf_bubble_cnt !== eb) begin
      errors++; $display("FAIL perf_totals: got %0d/%0d expected %0d/%0d", perf_fetch_cnt, perf_bubble_cnt, ef, eb);
    end
  endtask

  task automatic test_random();
    logic s, r;
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(3) == 0);
      r = ($urandom_range(7) == 0);
      t = $urandom;
      cycle(s, r, t);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
